// File: rtl/io_step_clock_controller.sv
// Alternate CPU clock source used while the core executes IN, OUT, OUT2 or HLT.
// For the IO opcodes it emits one PULSE_CYCLES-wide high pulse per debounced
// operator confirm press. On HLT it holds the alternate clock low until reset.
// The FSM state is exposed on state_dbg with the encoding:
//   0 IDLE, 1 WAIT_PRESS, 2 PULSE, 3 WAIT_RELEASE, 4 HALTED.
module io_step_clock_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] operation,
  input  logic       confirm_button,
  output logic       io_clock,
  output logic       waiting,
  output logic       halted,
  output logic [2:0] state_dbg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(PULSE_CYCLES) + 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);

  localparam logic [5:0] OP_IN   = 6'b011101;
  localparam logic [5:0] OP_OUT  = 6'b011110;
  localparam logic [5:0] OP_OUT2 = 6'b100000;
  localparam logic [5:0] OP_HLT  = 6'b011100;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_PRESS   = 3'd1,
    S_PULSE        = 3'd2,
    S_WAIT_RELEASE = 3'd3,
    S_HALTED       = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic          sync1;
  logic          sync2;
  logic          btn_stable;
  logic [DW-1:0] db_cnt;
  logic          press;
  logic [PW-1:0] pulse_cnt;

  logic is_io;
  logic is_hlt;

  logic io_clock_d;
  logic waiting_d;
  logic halted_d;

  assign is_io  = (operation == OP_IN) || (operation == OP_OUT) || (operation == OP_OUT2);
  assign is_hlt = (operation == OP_HLT);

  assign state_dbg = state;

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= confirm_button;
      sync2 <= sync1;
    end
  end

  // Debounce: the stable level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples. press is registered on the same edge as the rising
  // flip, so the FSM sees it one edge after btn_stable is computed.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_stable <= 1'b0;
      db_cnt     <= '0;
      press      <= 1'b0;
    end else if (sync2 != btn_stable) begin
      if (db_cnt == DB_LAST) begin
        btn_stable <= sync2;
        db_cnt     <= '0;
        press      <= sync2;
      end else begin
        db_cnt <= db_cnt + DW'(1);
        press  <= 1'b0;
      end
    end else begin
      db_cnt <= '0;
      press  <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pulse width counter: loaded on the accepting press, counts down in PULSE.
  always_ff @(posedge clock) begin
    if (reset) begin
      pulse_cnt <= '0;
    end else if ((state == S_WAIT_PRESS) && press) begin
      pulse_cnt <= PULSE_LOAD;
    end else if ((state == S_PULSE) && (pulse_cnt != '0)) begin
      pulse_cnt <= pulse_cnt - PW'(1);
    end
  end

  // Next-state logic. A press outside WAIT_PRESS is simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (is_io) begin
          state_next = S_WAIT_PRESS;
        end else if (is_hlt) begin
          state_next = S_HALTED;
        end
      end
      S_WAIT_PRESS: begin
        if (press) begin
          state_next = S_PULSE;
        end else if (!is_io) begin
          state_next = S_IDLE;
        end
      end
      S_PULSE: begin
        if (pulse_cnt == '0) begin
          state_next = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (!btn_stable) begin
          state_next = S_IDLE;
        end
      end
      S_HALTED: begin
        state_next = S_HALTED;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs change on
  // the same edge as the state itself.
  always_comb begin
    io_clock_d = 1'b0;
    waiting_d  = 1'b0;
    halted_d   = 1'b0;
    case (state_next)
      S_WAIT_PRESS: waiting_d  = 1'b1;
      S_PULSE:      io_clock_d = 1'b1;
      S_HALTED:     halted_d   = 1'b1;
      default: begin
        io_clock_d = 1'b0;
      end
    endcase
  end

  // Output registers; no input reaches an output without passing a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_clock <= 1'b0;
      waiting  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      io_clock <= io_clock_d;
      waiting  <= waiting_d;
      halted   <= halted_d;
    end
  end

endmodule

// File: tb/tb_io_step_clock_controller.sv
// Bench for io_step_clock_controller with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2.
// A behavioural model tracks raw button history, debounced level and the
// operator-visible mode; directed scenarios plus a randomized phase follow.
module tb_io_step_clock_controller;

  localparam int D = 4;
  localparam int P = 2;

  localparam logic [5:0] OP_NOP  = 6'b000001;
  localparam logic [5:0] OP_IN   = 6'b011101;
  localparam logic [5:0] OP_OUT  = 6'b011110;
  localparam logic [5:0] OP_OUT2 = 6'b100000;
  localparam logic [5:0] OP_HLT  = 6'b011100;

  localparam int MD_IDLE    = 0;
  localparam int MD_WAIT    = 1;
  localparam int MD_PULSE   = 2;
  localparam int MD_RELEASE = 3;
  localparam int MD_HALT    = 4;

  // clock / reset block
  logic       clock = 1'b0;
  logic       drv_rst = 1'b1;
  logic [5:0] drv_op = OP_NOP;
  logic       drv_btn = 1'b0;

  logic       io_clock;
  logic       waiting;
  logic       halted;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  io_step_clock_controller #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P)
  ) dut (
    .clock         (clock),
    .reset         (drv_rst),
    .operation     (drv_op),
    .confirm_button(drv_btn),
    .io_clock      (io_clock),
    .waiting       (waiting),
    .halted        (halted),
    .state_dbg     (state_dbg)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [2:0] exp_q[$];

  // behavioural model
  logic raw_q[$] = '{1'b0, 1'b0};
  logic m_level  = 1'b0;
  int   m_run    = 0;
  logic m_press  = 1'b0;
  int   m_mode   = MD_IDLE;
  int   m_high_left = 0;

  // watch counters for directed timing checks
  int   rises;
  int   highs;
  int   first_rise;
  int   first_fall;
  logic prev_io;

  function automatic logic is_io_op(input logic [5:0] op);
    return (op == OP_IN) || (op == OP_OUT) || (op == OP_OUT2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_edge();
    logic sample;
    logic press_now;
    if (drv_rst) begin
      raw_q       = '{1'b0, 1'b0};
      m_level     = 1'b0;
      m_run       = 0;
      m_press     = 1'b0;
      m_mode      = MD_IDLE;
      m_high_left = 0;
    end else begin
      // the button reaches the debouncer two edges after it was sampled
      sample    = raw_q[raw_q.size() - 2];
      press_now = m_press;
      case (m_mode)
        MD_IDLE: begin
          if (is_io_op(drv_op)) m_mode = MD_WAIT;
          else if (drv_op == OP_HLT) m_mode = MD_HALT;
        end
        MD_WAIT: begin
          if (press_now) begin
            m_mode      = MD_PULSE;
            m_high_left = P;
          end else if (!is_io_op(drv_op)) begin
            m_mode = MD_IDLE;
          end
        end
        MD_PULSE: begin
          m_high_left--;
          if (m_high_left == 0) m_mode = MD_RELEASE;
        end
        MD_RELEASE: begin
          if (!m_level) m_mode = MD_IDLE;
        end
        default: begin
        end
      endcase
      m_press = 1'b0;
      if (sample != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = sample;
          m_run   = 0;
          m_press = sample;
        end
      end else begin
        m_run = 0;
      end
      raw_q.push_back(drv_btn);
      if (raw_q.size() > 4) void'(raw_q.pop_front());
    end
    exp_q.push_back({m_mode == MD_PULSE, m_mode == MD_WAIT, m_mode == MD_HALT});
  endtask

  // driver: one edge with current inputs, then model compare away from the edge
  task automatic tick();
    logic [2:0] e;
    @(posedge clock);
    cyc++;
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("io_clock", 32'(io_clock), 32'(e[2]));
    check("waiting", 32'(waiting), 32'(e[1]));
    check("halted", 32'(halted), 32'(e[0]));
    check("state_dbg", 32'(state_dbg), 32'(m_mode));
    if (io_clock === 1'b1) begin
      highs++;
      if (prev_io !== 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = cyc;
      end
    end else if (prev_io === 1'b1 && first_fall < 0) begin
      first_fall = cyc;
    end
    prev_io = io_clock;
  endtask

  task automatic run(input int n, input logic [5:0] op, input logic btn);
    drv_op  = op;
    drv_btn = btn;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_watch();
    rises      = 0;
    highs      = 0;
    first_rise = -1;
    first_fall = -1;
  endtask

  int k;
  int found;
  logic pat[5];

  initial begin
    prev_io = 1'b0;
    clear_watch();

    // 1: reset, non-IO opcode, button activity ignored
    drv_rst = 1'b1;
    run(2, OP_NOP, 1'b0);
    drv_rst = 1'b0;
    check("reset_state", 32'(state_dbg), 32'(MD_IDLE));
    check("reset_io", 32'(io_clock), 32'd0);
    clear_watch();
    run(5, OP_NOP, 1'b0);
    run(10, OP_NOP, 1'b1);
    run(5, OP_NOP, 1'b0);
    run(8, OP_NOP, 1'b0);
    check("t1_no_pulse", 32'(highs), 32'd0);
    check("t1_idle", 32'(state_dbg), 32'(MD_IDLE));

    // 2: clean press on IN
    run(1, OP_IN, 1'b0);
    check("t2_waiting", 32'(waiting), 32'd1);
    clear_watch();
    k = cyc + 1;
    run(20, OP_IN, 1'b1);
    check("t2_rise", 32'(first_rise), 32'(k + D + 2));
    check("t2_fall", 32'(first_fall), 32'(k + D + 2 + P));
    check("t2_one_pulse", 32'(rises), 32'd1);
    run(12, OP_NOP, 1'b0);

    // 3: bouncy press on OUT
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run(1, OP_OUT, 1'b0);
    clear_watch();
    k = cyc + 5;
    for (int i = 0; i < 5; i++) run(1, OP_OUT, pat[i]);
    run(14, OP_OUT, 1'b1);
    check("t3_rise", 32'(first_rise), 32'(k + D + 2));
    check("t3_highs", 32'(highs), 32'(P));
    check("t3_one_pulse", 32'(rises), 32'd1);
    run(12, OP_NOP, 1'b0);

    // 4: held button across opcode change, then release and re-press
    run(1, OP_OUT2, 1'b0);
    clear_watch();
    run(12, OP_OUT2, 1'b1);
    run(10, OP_IN, 1'b1);
    check("t4_single", 32'(rises), 32'd1);
    run(10, OP_IN, 1'b0);
    check("t4_wait_again", 32'(waiting), 32'd1);
    clear_watch();
    run(14, OP_IN, 1'b1);
    check("t4_second", 32'(rises), 32'd1);
    check("t4_second_w", 32'(highs), 32'(P));
    run(12, OP_NOP, 1'b0);

    // 5: HLT is absorbing until reset
    run(1, OP_HLT, 1'b0);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_io_low", 32'(io_clock), 32'd0);
    clear_watch();
    for (int i = 0; i < 20; i++) begin
      run(1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end
    run(10, OP_IN, 1'b1);
    check("t5_quiet", 32'(highs), 32'd0);
    check("t5_still_halt", 32'(halted), 32'd1);
    drv_rst = 1'b1;
    run(1, OP_NOP, 1'b0);
    drv_rst = 1'b0;
    check("t5_unhalt", 32'(halted), 32'd0);
    check("t5_idle", 32'(state_dbg), 32'(MD_IDLE));

    // 6: reset during the first pulse cycle, then full latency again
    run(2, OP_IN, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      run(1, OP_IN, 1'b1);
      if (io_clock === 1'b1) found = 1;
    end
    check("t6_pulse_seen", 32'(found), 32'd1);
    drv_rst = 1'b1;
    run(1, OP_IN, 1'b1);
    drv_rst = 1'b0;
    check("t6_reset_io", 32'(io_clock), 32'd0);
    clear_watch();
    prev_io = 1'b0;
    k = cyc + 1;
    run(14, OP_IN, 1'b1);
    check("t6_rise", 32'(first_rise), 32'(k + D + 2));
    check("t6_highs", 32'(highs), 32'(P));
    run(12, OP_NOP, 1'b0);

    // randomized phase against the model
    for (int seg = 0; seg < 60; seg++) begin
      int sel;
      logic [5:0] op;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = OP_IN;
        2:       op = OP_OUT;
        3:       op = OP_OUT2;
        4:       op = ($urandom_range(0, 3) == 0) ? OP_HLT : OP_NOP;
        5, 6:    op = drv_op;
        default: op = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 11) == 0) begin
        drv_rst = 1'b1;
        run(1, op, drv_btn);
        drv_rst = 1'b0;
      end
      run($urandom_range(1, 12), op, ~drv_btn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
